seq_scan_arbiter: RTL and testbench
===================================

# seq_scan_arbiter

Two-requester front end for the serial 1101 sequence detector. It arbitrates between two clients that each offer a parallel word, then shifts the granted word MSB-first through an embedded Mealy 1101 detector (states A–E). It counts the matches and returns the count to the winning client with a done pulse. It sits between parallel producers and the serial detector so that one detection resource is shared, one word at a time.

## Interface
- WORD_W, 8, width of each requester's data word (≥4)
- CNT_W, 4, width of match counter (saturating)

- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from client 0 / 1; held until matching gnt
- data0 / data1  in  WORD_W  word offered by client 0 / 1; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: word captured, client may drop req
- busy  out  1  high from grant cycle through done cycle
- z  out  1  Mealy match output of detector for the bit currently being shifted
- done  out  1  one-cycle pulse: scan complete
- done_id  out  1  client whose word produced this result (0/1)
- match_count  out  CNT_W  matches found in last scanned word; held until next grant

## Operation
- Controller FSM: IDLE → SCAN → DONE → IDLE.
- IDLE:
  - If any req is high, choose a winner by round-robin.
  - Simultaneous requests: grant the client not granted last. The last-grant pointer resets to 1, so client 0 wins the first tie.
  - Single request: that client wins regardless of pointer.
  - Latch the winner's data into the shift register, clear match_count and bit index, set detector state to A, go to SCAN.
- SCAN:
  - Each cycle the current bit w = shift register MSB feeds the detector.
  - Shift register shifts left; index increments.
  - After WORD_W bits, go to DONE.
- Detector transitions:
  - A: 1→B, 0→A.
  - B: 1→C, 0→A.
  - C: 1→C, 0→D.
  - D: 1→E with z=1, 0→A.
  - E: 1→C, 0→A.
  - z=1 only when state D and w=1.
- Each z=1 increments match_count, saturating at 2^CNT_W−1.
- DONE: done=1 and done_id valid for one cycle; return to IDLE. Requests are not sampled in DONE.
- Reset mid-operation aborts the scan: no done, no gnt. All outputs return to reset values and the detector returns to state A.
- Reset values:
  - gnt0, gnt1, busy, z, done, done_id: 0.
  - match_count: 0.
  - Controller in IDLE; detector in A.

## Timing
- Edge k samples a request in IDLE. During cycle k→k+1: gntX=1, busy=1, z reflects bit WORD_W−1 (MSB).
- Cycle k+j→k+j+1 (j=0..WORD_W−1) presents bit WORD_W−1−j; z is combinational from that bit and the detector state.
- match_count updates at the edge ending each bit cycle and is final after edge k+WORD_W.
- Cycle k+WORD_W→k+WORD_W+1: done=1, busy=1, z=0.
- After edge k+WORD_W+1: IDLE, busy=0. The earliest next grant is sampled at edge k+WORD_W+2.
- Occupancy per word: WORD_W+2 cycles.
- A requester whose req stays high after its gnt is treated as a new request.

## Configuration
- SEQ_SCAN_OVERLAP_EN defined: overlapping matches are counted. After a match the detector sits in E and follows E's transitions (E on 1→C), so the trailing 1 of one match can start the next.
- Not defined: non-overlapping. The state after a match (D on w=1) is A instead of E, and E is unreachable. All other transitions are unchanged.

## Test plan
- Reset, then req0=1, data0=8'b11011011:
  - Overlap build: gnt0 pulse, z high on bits 3 and 6 (MSB = bit 0), done after 9 cycles, done_id=0, match_count=2.
  - Non-overlap build: single z pulse, match_count=1.
- req1 only, data1=8'hFF → gnt1, z never high, done_id=1, match_count=0.
- req0 and req1 both high after reset, data0=8'b01101101, data1=8'h0D → client 0 scanned first (count 2 overlap / 1 non-overlap), then client 1 (count 1). Two consecutive ties alternate 0, 1, 0.
- Resetn pulsed low at bit 4 of a scan → busy, z, match_count return to 0 immediately; no done pulse; next request is granted normally.
- Back-to-back req0 held continuously → grants spaced exactly WORD_W+2 cycles apart; match_count holds between done and the next gnt.
- CNT_W=1 build, word 8'b11011011, overlap → match_count saturates at 1.

Source files
------------

// File: rtl/seq_scan_arbiter.sv
// ----------------------------------------------------------------------------
// seq_scan_arbiter
//
// Two-client front end for a serial "1101" Mealy detector. In IDLE it picks
// a requester (round-robin on ties), captures that client's word, then shifts
// the word MSB-first through the detector for WORD_W cycles. It counts the
// matches, with saturation, and reports the count with a one-cycle done pulse.
//
// Build option:
//   SEQ_SCAN_OVERLAP_EN  defined     -> overlapping matches are counted
//                                       (D --1--> E).
//                        not defined -> non-overlapping (D --1--> A).
//                                       E is unreachable.
//
// Parameters:
//   WORD_W       width of each client's data word (>= 4)
//   CNT_W        width of the saturating match counter
//
// Ports:
//   Clock        rising-edge clock
//   Resetn       asynchronous active-low reset
//   req0/req1    client requests, held until the matching grant
//   data0/data1  client words, stable while req is high
//   gnt0/gnt1    one-cycle grant pulse (word captured)
//   busy         high from the grant cycle through the done cycle
//   z            Mealy match output for the bit being shifted this cycle
//   done         one-cycle pulse when the scan is complete
//   done_id      client that owns the result (qualified by done)
//   match_count  matches in the last scanned word; held until the next grant
// ----------------------------------------------------------------------------
//
// Controller states
//   state  | meaning
//   S_IDLE | waiting for a request; arbitration happens here
//   S_SCAN | one word bit per cycle through the detector
//   S_DONE | result cycle; requests are ignored
//
// Detector states
//   state  | meaning
//   D_A    | no useful prefix
//   D_B    | seen "1"
//   D_C    | seen "11"
//   D_D    | seen "110"
//   D_E    | just matched "1101" (reachable only in the overlap build)

module seq_scan_arbiter #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic [WORD_W-1:0] data0,
    input  logic [WORD_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              z,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  match_count
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } ctl_t;

    typedef enum logic [2:0] {
        D_A,
        D_B,
        D_C,
        D_D,
        D_E
    } det_t;

    ctl_t              ctl_q, ctl_d;
    det_t              det_q, det_d, det_nxt;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;    // client granted most recently
    logic              owner_q, owner_d;  // client whose word is in flight

    logic w;
    logic z_det;
    logic win;

    assign w = sreg_q[WORD_W-1];

    // Detector transition for the bit currently at the MSB of the shift register.
    always_comb begin
        det_nxt = D_A;
        z_det   = 1'b0;
        case (det_q)
            D_A: det_nxt = w ? D_B : D_A;
            D_B: det_nxt = w ? D_C : D_A;
            D_C: det_nxt = w ? D_C : D_D;
            D_D: begin
                z_det = w;
`ifdef SEQ_SCAN_OVERLAP_EN
                det_nxt = w ? D_E : D_A;
`else
                det_nxt = D_A;
`endif
            end
            D_E:     det_nxt = w ? D_C : D_A;
            default: det_nxt = D_A;
        endcase
    end

    // On a tie the client that was not granted last wins. A single request
    // wins regardless of the pointer.
    always_comb begin
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
    end

    always_comb begin
        ctl_d   = ctl_q;
        det_d   = det_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        case (ctl_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    ctl_d   = S_SCAN;
                    owner_d = win;
                    last_d  = win;
                    sreg_d  = win ? data1 : data0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    det_d   = D_A;
                end
            end
            S_SCAN: begin
                det_d  = det_nxt;
                sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
                idx_d  = idx_q + IDX_W'(1);
                if (z_det && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (idx_q == LAST_IDX) begin
                    ctl_d = S_DONE;
                end
            end
            S_DONE: begin
                ctl_d = S_IDLE;
            end
            default: begin
                ctl_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ctl_q   <= S_IDLE;
            det_q   <= D_A;
            sreg_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            det_q   <= det_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // The grant pulse is the first scan cycle. It is decoded from registered
    // state, so it is glitch-free and lines up with the MSB being presented.
    assign gnt0        = (ctl_q == S_SCAN) && (idx_q == '0) && !owner_q;
    assign gnt1        = (ctl_q == S_SCAN) && (idx_q == '0) && owner_q;
    assign busy        = (ctl_q != S_IDLE);
    assign z           = (ctl_q == S_SCAN) && z_det;
    assign done        = (ctl_q == S_DONE);
    assign done_id     = (ctl_q == S_DONE) && owner_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
module tb_seq_scan_arbiter;

    localparam int W  = 8;
    localparam int CW = 4;

`ifdef SEQ_SCAN_OVERLAP_EN
    localparam logic [7:0] ZM_DB  = 8'b0001_0010;
    localparam int         CNT_DB = 2;
    localparam logic [7:0] ZM_6D  = 8'b0000_1001;
    localparam int         CNT_6D = 2;
`else
    localparam logic [7:0] ZM_DB  = 8'b0001_0000;
    localparam int         CNT_DB = 1;
    localparam logic [7:0] ZM_6D  = 8'b0000_1000;
    localparam int         CNT_6D = 1;
`endif
    localparam logic [7:0] ZM_0D  = 8'b0000_0001;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  data0 = '0, data1 = '0;
    logic          gnt0, gnt1, busy, z, done, done_id;
    logic [CW-1:0] match_count;

    logic          s_gnt0, s_gnt1, s_busy, s_z, s_done, s_done_id;
    logic [0:0]    s_match_count;

    seq_scan_arbiter #(.WORD_W(W), .CNT_W(CW)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .z(z),
        .done(done), .done_id(done_id), .match_count(match_count)
    );

    seq_scan_arbiter #(.WORD_W(W), .CNT_W(1)) dut_sat (
        .Clock(Clock), .Resetn(Resetn),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy), .z(s_z),
        .done(s_done), .done_id(s_done_id), .match_count(s_match_count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       id;
        logic [7:0] zmask;
        logic [3:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [7:0] zm, input int cnt);
        exp_t e;
        e.id    = id;
        e.zmask = zm;
        e.cnt   = 4'(cnt);
        return e;
    endfunction

    // Monitor: pops the expected result at each grant and checks it
    // bit by bit through the done cycle.
    bit         in_prog = 0;
    exp_t       cur;
    logic [7:0] zcol;
    int         bitn = 0;
    int         last_cnt = 0;
    int         cyc = 0;
    int         gnt_cnt = 0;
    int         gnt_cyc[$];

    always @(negedge Clock) begin
        cyc++;
        if (!Resetn) begin
            in_prog  = 0;
            bitn     = 0;
            last_cnt = 0;
        end else begin
            if (gnt0 || gnt1) begin
                check("gnt_exclusive", int'(gnt0 && gnt1), 0);
                check("gnt_while_scanning", int'(in_prog), 0);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL gnt_unexpected actual=gnt0:%0d,gnt1:%0d required=no grant", gnt0, gnt1);
                    cur = mk(1'b0, 8'h00, 0);
                end else begin
                    cur = sbq.pop_front();
                    check("gnt_id", int'(gnt1), int'(cur.id));
                end
                in_prog = 1;
                bitn    = 0;
                zcol    = '0;
                gnt_cnt++;
                gnt_cyc.push_back(cyc);
            end
            if (in_prog) begin
                if (bitn < W) begin
                    zcol = {zcol[6:0], z};
                    bitn++;
                    check("busy_scan", int'(busy), 1);
                    check("done_early", int'(done), 0);
                end else begin
                    check("done_pulse", int'(done), 1);
                    check("done_id", int'(done_id), int'(cur.id));
                    check("match_count", int'(match_count), int'(cur.cnt));
                    check("z_mask", int'(zcol), int'(cur.zmask));
                    check("z_in_done", int'(z), 0);
                    check("busy_done", int'(busy), 1);
                    check("sat_count", int'(s_match_count), int'(cur.cnt != 0));
                    last_cnt = int'(cur.cnt);
                    in_prog  = 0;
                end
            end else begin
                check("done_spurious", int'(done), 0);
                check("busy_idle", int'(busy), 0);
                check("count_hold", int'(match_count), last_cnt);
            end
        end
    end

    task automatic wait_grants(input int n);
        int tgt;
        tgt = gnt_cnt + n;
        for (int k = 0; k < 200 && gnt_cnt < tgt; k++) begin
            @(negedge Clock);
            #1;
        end
        check("grant_timeout", int'(gnt_cnt >= tgt), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && (busy || in_prog); k++) begin
            @(negedge Clock);
            #1;
        end
        check("idle_timeout", int'(busy || in_prog), 0);
    endtask

    task automatic issue(input logic id, input logic [7:0] d, input exp_t e);
        sbq.push_back(e);
        if (id) begin
            data1 = d;
            req1  = 1'b1;
        end else begin
            data0 = d;
            req0  = 1'b1;
        end
        wait_grants(1);
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
        wait_idle();
    endtask

    task automatic pulse_reset();
        Resetn = 1'b0;
        @(negedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (2) begin
            @(negedge Clock);
            #1;
        end
        check("rst_gnt0", int'(gnt0), 0);
        check("rst_gnt1", int'(gnt1), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_z", int'(z), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_count", int'(match_count), 0);
        Resetn = 1'b1;

        issue(1'b0, 8'b1101_1011, mk(1'b0, ZM_DB, CNT_DB));
        issue(1'b1, 8'hFF, mk(1'b1, 8'h00, 0));

        // Ties held across four grants alternate 0,1,0,1 from reset.
        pulse_reset();
        sbq.push_back(mk(1'b0, ZM_6D, CNT_6D));
        sbq.push_back(mk(1'b1, ZM_0D, 1));
        sbq.push_back(mk(1'b0, ZM_6D, CNT_6D));
        sbq.push_back(mk(1'b1, ZM_0D, 1));
        data0 = 8'b0110_1101;
        data1 = 8'h0D;
        req0  = 1'b1;
        req1  = 1'b1;
        wait_grants(4);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();

        // Reset during bit 4 of a scan.
        sbq.push_back(mk(1'b0, ZM_DB, CNT_DB));
        data0 = 8'b1101_1011;
        req0  = 1'b1;
        wait_grants(1);
        req0 = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            #1;
        end
        check("pre_reset_count", int'(match_count), 1);
        check("pre_reset_busy", int'(busy), 1);
        Resetn = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_z", int'(z), 0);
        check("abort_count", int'(match_count), 0);
        check("abort_gnt", int'(gnt0 || gnt1), 0);
        @(negedge Clock);
        #1;
        Resetn = 1'b1;
        repeat (12) begin
            @(negedge Clock);
            #1;
        end
        issue(1'b1, 8'h0D, mk(1'b1, ZM_0D, 1));

        // Continuous req0: grants spaced WORD_W+2 cycles apart.
        n0 = gnt_cyc.size();
        sbq.push_back(mk(1'b0, ZM_DB, CNT_DB));
        sbq.push_back(mk(1'b0, ZM_DB, CNT_DB));
        sbq.push_back(mk(1'b0, ZM_DB, CNT_DB));
        data0 = 8'b1101_1011;
        req0  = 1'b1;
        wait_grants(3);
        req0 = 1'b0;
        wait_idle();
        if (gnt_cyc.size() >= n0 + 3) begin
            check("b2b_spacing_1", gnt_cyc[n0+1] - gnt_cyc[n0], W + 2);
            check("b2b_spacing_2", gnt_cyc[n0+2] - gnt_cyc[n0+1], W + 2);
        end else begin
            check("b2b_grant_count", gnt_cyc.size() - n0, 3);
        end
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
